// File: rtl/stock_pkg.sv
// Shared types and helpers for the stock tracker: select-width calculation,
// saturating add, and the per-cell update operation encoding.
package stock_pkg;

  typedef enum logic [1:0] {
    OP_HOLD     = 2'd0,
    OP_UPDATE   = 2'd1,
    OP_LOAD_MAX = 2'd2
  } cell_op_e;

  // Item-select width: a single bit is kept even when only one select value exists.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Sum is formed one bit wider than the operands, so it never wraps before clamping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/stock_cell.sv
// One item's stock register: vend decrement, saturating restock and global
// refill, with empty/low status derived from the stored value.
module stock_cell
  import stock_pkg::*;
#(
  parameter int QTY_W      = 6,
  parameter int START_QTY  = 5,
  parameter int MAX_QTY    = 20,
  parameter int LOW_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_i,
  input  logic             add_en_i,
  input  logic [QTY_W-1:0] add_qty_i,
  input  logic             load_max_i,
  output logic [QTY_W-1:0] value_o,
  output logic             empty_o,
  output logic             low_o
);

  localparam logic [QTY_W-1:0] START_V = QTY_W'(START_QTY);
  localparam logic [QTY_W-1:0] MAX_V   = QTY_W'(MAX_QTY);
  localparam logic [QTY_W-1:0] LOW_V   = QTY_W'(LOW_THRESH);

  logic [QTY_W-1:0] value_q, value_d;
  logic [QTY_W-1:0] base;
  cell_op_e         op;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    value_d = value_q;
    base    = value_q - QTY_W'(dec_i);
    if (load_max_i)            op = OP_LOAD_MAX;
    else if (dec_i || add_en_i) op = OP_UPDATE;
    else                        op = OP_HOLD;

    unique case (op)
      OP_LOAD_MAX: value_d = MAX_V;
      OP_UPDATE:   value_d = add_en_i
                             ? QTY_W'(sat_add(32'(base), 32'(add_qty_i), 32'(MAX_V)))
                             : base;
      default:     value_d = value_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) value_q <= START_V;
    else     value_q <= value_d;
  end

  assign value_o = value_q;
  assign empty_o = (value_q == '0);
  assign low_o   = (value_q <= LOW_V);

endmodule

// File: rtl/stock_manager.sv
// Multi-item stock tracker: vend accept/reject, saturating restock, global
// refill, sold-out/low masks, low-stock alert and a wrapping sales counter.
module stock_manager
  import stock_pkg::*;
#(
  parameter  int ITEM_COUNT = 8,
  parameter  int QTY_W      = 6,
  parameter  int START_QTY  = 5,
  parameter  int MAX_QTY    = 20,
  parameter  int LOW_THRESH = 2,
  parameter  int SALES_W    = 16,
  localparam int SEL_W      = sel_width(ITEM_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vend_req,
  input  logic [SEL_W-1:0]      vend_item,
  output logic                  vend_ack,
  output logic                  vend_nak,
  input  logic                  restock_req,
  input  logic [SEL_W-1:0]      restock_item,
  input  logic [QTY_W-1:0]      restock_qty,
  input  logic                  refill_all,
  input  logic [SEL_W-1:0]      query_item,
  output logic [QTY_W-1:0]      stock_level,
  output logic [ITEM_COUNT-1:0] sold_out_mask,
  output logic [ITEM_COUNT-1:0] low_mask,
  output logic                  low_alert,
  output logic [SEL_W-1:0]      low_item,
  output logic [SALES_W-1:0]    sales_total
);

  localparam int                    PAD_W     = 1 << SEL_W;
  localparam logic [SEL_W:0]        ITEM_LIM  = (SEL_W + 1)'(ITEM_COUNT);
  localparam logic [ITEM_COUNT-1:0] RESET_LOW = {ITEM_COUNT{START_QTY <= LOW_THRESH}};

  logic [QTY_W-1:0]      stock [ITEM_COUNT];
  logic [QTY_W-1:0]      stock_pad [PAD_W];
  logic [ITEM_COUNT-1:0] empty_vec, low_vec;
  logic [PAD_W-1:0]      empty_pad;

  logic vend_in_range, restock_in_range, vend_accept;

  logic                  vend_ack_q, vend_ack_d;
  logic                  vend_nak_q, vend_nak_d;
  logic [ITEM_COUNT-1:0] low_prev_q, low_prev_d;
  logic [SALES_W-1:0]    sales_q, sales_d;
  logic [ITEM_COUNT-1:0] low_rise;

  // Request decode: refill wins over both vend and restock.
  assign vend_in_range    = ({1'b0, vend_item} < ITEM_LIM);
  assign restock_in_range = ({1'b0, restock_item} < ITEM_LIM);
  assign empty_pad        = PAD_W'(empty_vec);
  assign vend_accept      = vend_req && !refill_all && vend_in_range && !empty_pad[vend_item];

  for (genvar g = 0; g < ITEM_COUNT; g++) begin : g_cell
    stock_cell #(
      .QTY_W      (QTY_W),
      .START_QTY  (START_QTY),
      .MAX_QTY    (MAX_QTY),
      .LOW_THRESH (LOW_THRESH)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .dec_i      (vend_accept && (vend_item == SEL_W'(g))),
      .add_en_i   (restock_req && !refill_all && restock_in_range &&
                   (restock_item == SEL_W'(g))),
      .add_qty_i  (restock_qty),
      .load_max_i (refill_all),
      .value_o    (stock[g]),
      .empty_o    (empty_vec[g]),
      .low_o      (low_vec[g])
    );
  end

  // Padding the read array to the full select range makes out-of-range queries read 0.
  always_comb begin
    for (int i = 0; i < PAD_W; i++) stock_pad[i] = '0;
    for (int i = 0; i < ITEM_COUNT; i++) stock_pad[i] = stock[i];
  end

  always_comb begin
    vend_ack_d = vend_accept;
    vend_nak_d = vend_req && !vend_accept;
    low_prev_d = low_vec;
    sales_d    = sales_q + SALES_W'(vend_accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vend_ack_q <= 1'b0;
      vend_nak_q <= 1'b0;
      low_prev_q <= RESET_LOW;
      sales_q    <= '0;
    end else begin
      vend_ack_q <= vend_ack_d;
      vend_nak_q <= vend_nak_d;
      low_prev_q <= low_prev_d;
      sales_q    <= sales_d;
    end
  end

  // Lowest-index item among those whose low bit just rose.
  assign low_rise = low_vec & ~low_prev_q;
  always_comb begin
    low_item = '0;
    for (int i = ITEM_COUNT - 1; i >= 0; i--) begin
      if (low_rise[i]) low_item = SEL_W'(i);
    end
  end

  assign vend_ack      = vend_ack_q;
  assign vend_nak      = vend_nak_q;
  assign stock_level   = stock_pad[query_item];
  assign sold_out_mask = empty_vec;
  assign low_mask      = low_vec;
  assign low_alert     = |low_rise;
  assign sales_total   = sales_q;

endmodule

// File: tb/tb_stock_manager.sv
// Self-checking bench for stock_manager: directed scenarios with literal
// expectations plus randomized traffic against an array-based stock model.
module tb_stock_manager;

  localparam int N     = 6;
  localparam int QW    = 6;
  localparam int START = 5;
  localparam int MAXQ  = 20;
  localparam int LOWT  = 2;
  localparam int SW    = 16;
  localparam int SELW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            vend_req = 1'b0;
  logic [SELW-1:0] vend_item = '0;
  logic            vend_ack, vend_nak;
  logic            restock_req = 1'b0;
  logic [SELW-1:0] restock_item = '0;
  logic [QW-1:0]   restock_qty = '0;
  logic            refill_all = 1'b0;
  logic [SELW-1:0] query_item = '0;
  logic [QW-1:0]   stock_level;
  logic [N-1:0]    sold_out_mask, low_mask;
  logic            low_alert;
  logic [SELW-1:0] low_item;
  logic [SW-1:0]   sales_total;

  stock_manager #(
    .ITEM_COUNT (N), .QTY_W (QW), .START_QTY (START),
    .MAX_QTY (MAXQ), .LOW_THRESH (LOWT), .SALES_W (SW)
  ) dut (
    .clk (clk), .rst (rst),
    .vend_req (vend_req), .vend_item (vend_item),
    .vend_ack (vend_ack), .vend_nak (vend_nak),
    .restock_req (restock_req), .restock_item (restock_item), .restock_qty (restock_qty),
    .refill_all (refill_all), .query_item (query_item),
    .stock_level (stock_level), .sold_out_mask (sold_out_mask), .low_mask (low_mask),
    .low_alert (low_alert), .low_item (low_item), .sales_total (sales_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: plain stock counts and the expected registered responses.
  int m_stock [N];
  int m_sales;
  bit m_ack, m_nak, m_alert;
  int m_low_item;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_stock[i] = START;
    m_sales = 0; m_ack = 0; m_nak = 0; m_alert = 0; m_low_item = 0;
  endtask

  task automatic model_step(input bit vr, input int vi, input bit rr, input int ri,
                            input int rq, input bit rf);
    bit old_low [N];
    bit acc;
    for (int i = 0; i < N; i++) old_low[i] = (m_stock[i] <= LOWT);
    if (rf) begin
      m_ack = 0;
      m_nak = vr;
      for (int i = 0; i < N; i++) m_stock[i] = MAXQ;
    end else begin
      acc = 0;
      if (vr && vi < N) acc = (m_stock[vi] != 0);
      m_ack = acc;
      m_nak = vr && !acc;
      if (acc) begin
        m_stock[vi] = m_stock[vi] - 1;
        m_sales = (m_sales + 1) % (1 << SW);
      end
      if (rr && ri < N) m_stock[ri] = (m_stock[ri] + rq > MAXQ) ? MAXQ : m_stock[ri] + rq;
    end
    m_alert = 0;
    m_low_item = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_alert && m_stock[i] <= LOWT && !old_low[i]) begin
        m_alert = 1;
        m_low_item = i;
      end
    end
  endtask

  // Drive one cycle of requests; model advances on the same edge as the DUT.
  task automatic do_cycle(input bit vr, input int vi, input bit rr, input int ri,
                          input int rq, input bit rf, input int qi);
    vend_req = vr; vend_item = SELW'(vi);
    restock_req = rr; restock_item = SELW'(ri); restock_qty = QW'(rq);
    refill_all = rf; query_item = SELW'(qi);
    @(posedge clk);
    model_step(vr, vi, rr, ri, rq, rf);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_so, exp_low, exp_lvl;
      exp_so = 0; exp_low = 0;
      for (int i = 0; i < N; i++) begin
        if (m_stock[i] == 0)    exp_so  |= (1 << i);
        if (m_stock[i] <= LOWT) exp_low |= (1 << i);
      end
      exp_lvl = (int'(query_item) < N) ? m_stock[query_item] : 0;
      check("vend_ack", vend_ack, m_ack);
      check("vend_nak", vend_nak, m_nak);
      check("stock_level", stock_level, exp_lvl);
      check("sold_out_mask", sold_out_mask, exp_so);
      check("low_mask", low_mask, exp_low);
      check("low_alert", low_alert, m_alert);
      if (m_alert) check("low_item", low_item, m_low_item);
      check("sales_total", sales_total, m_sales);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    check("rst_stock_level", stock_level, 5);
    check("rst_sold_out", sold_out_mask, 0);
    check("rst_sales", sales_total, 0);
    check("rst_ack", vend_ack, 0);

    // Drain item 3: five accepts then a reject.
    for (int k = 0; k < 6; k++) begin
      do_cycle(1, 3, 0, 0, 0, 0, 3);
      check("drain_ack", vend_ack, (k < 5) ? 1 : 0);
      check("drain_nak", vend_nak, (k < 5) ? 0 : 1);
    end
    check("drain_sold_out3", sold_out_mask[3], 1);
    check("drain_sales", sales_total, 5);

    do_cycle(0, 0, 1, 0, 30, 0, 0);
    check("restock_sat", stock_level, 20);
    do_cycle(0, 0, 1, 0, 0, 0, 0);
    check("restock_zero", stock_level, 20);

    do_cycle(1, 2, 1, 2, 4, 0, 2);
    check("same_item_ack", vend_ack, 1);
    check("same_item_level", stock_level, 8);

    // Item 1: 5 -> 4 -> 3 -> 2 alerts on the third accept only.
    for (int k = 0; k < 5; k++) begin
      do_cycle(1, 1, 0, 0, 0, 0, 1);
      check("low_walk_ack", vend_ack, 1);
      check("low_walk_alert", low_alert, (k == 2) ? 1 : 0);
      if (k == 2) check("low_walk_item", low_item, 1);
    end

    do_cycle(1, 7, 0, 0, 0, 0, 7);
    check("oor_vend_nak", vend_nak, 1);
    check("oor_query", stock_level, 0);
    do_cycle(0, 0, 1, 7, 3, 0, 0);
    check("oor_restock_so", sold_out_mask, 6'b001010);
    check("oor_restock_low", low_mask, 6'b001010);

    do_cycle(1, 4, 1, 4, 3, 1, 5);
    check("refill_nak", vend_nak, 1);
    check("refill_ack", vend_ack, 0);
    check("refill_level", stock_level, 20);
    check("refill_low", low_mask, 0);
    check("refill_alert", low_alert, 0);

    // Randomized traffic biased towards vends so items drain and refill.
    for (int k = 0; k < 1500; k++) begin
      do_cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 7),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4),
               ($urandom_range(0, 49) == 0), $urandom_range(0, 7));
    end

    // Asynchronous reset in mid-cycle with a vend request pending.
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    vend_req = 1'b1; vend_item = '0; restock_req = 1'b0; refill_all = 1'b0; query_item = '0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", vend_ack, 0);
    check("async_rst_nak", vend_nak, 0);
    check("async_rst_sales", sales_total, 0);
    check("async_rst_level", stock_level, 5);
    check("async_rst_alert", low_alert, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 vend_req = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ack", vend_ack, 0);
    check("post_rst_nak", vend_nak, 0);
    model_reset();
    chk_en = 1'b1;

    for (int k = 0; k < 300; k++) begin
      do_cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 7),
               ($urandom_range(0, 4) == 0), $urandom_range(0, 7),
               $urandom_range(0, 5), ($urandom_range(0, 99) == 0), $urandom_range(0, 7));
    end

    do_cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
